// File: rtl/tmds_pkg.sv
// Shared TMDS definitions for the transmit and receive paths.
// Holds symbol widths, the mode encoding, the control/TERC4/guard-band code
// words, and the stage-1 pipeline payload.
package tmds_pkg;

    localparam int unsigned SYM_W     = 10;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned QM_W      = 9;
    localparam int unsigned POP_W     = 4;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned CNT_EXT_W = 6;
    localparam int unsigned MODE_W    = 2;
    localparam int unsigned CTRL_W    = 2;
    localparam int unsigned TERC4_W   = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_CTRL  = 2'b00,
        MODE_VIDEO = 2'b01,
        MODE_TERC4 = 2'b10,
        MODE_GUARD = 2'b11
    } tmds_mode_e;

    localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

    localparam logic [SYM_W-1:0] TERC4_0 = 10'b1010011100;
    localparam logic [SYM_W-1:0] TERC4_1 = 10'b1001100011;
    localparam logic [SYM_W-1:0] TERC4_2 = 10'b1011100100;
    localparam logic [SYM_W-1:0] TERC4_3 = 10'b1011100010;
    localparam logic [SYM_W-1:0] TERC4_4 = 10'b0101110001;
    localparam logic [SYM_W-1:0] TERC4_5 = 10'b0100011110;
    localparam logic [SYM_W-1:0] TERC4_6 = 10'b0110001110;
    localparam logic [SYM_W-1:0] TERC4_7 = 10'b0100111100;
    localparam logic [SYM_W-1:0] TERC4_8 = 10'b1011001100;
    localparam logic [SYM_W-1:0] TERC4_9 = 10'b0100111001;
    localparam logic [SYM_W-1:0] TERC4_A = 10'b0110011100;
    localparam logic [SYM_W-1:0] TERC4_B = 10'b1011000110;
    localparam logic [SYM_W-1:0] TERC4_C = 10'b1010001110;
    localparam logic [SYM_W-1:0] TERC4_D = 10'b1001110001;
    localparam logic [SYM_W-1:0] TERC4_E = 10'b0101100011;
    localparam logic [SYM_W-1:0] TERC4_F = 10'b1011000011;

    localparam logic [SYM_W-1:0] GUARD_C0C2 = 10'b1011001100;
    localparam logic [SYM_W-1:0] GUARD_C1   = 10'b0100110011;

    // Stage-1 payload: sampled controls plus the minimised video word.
    typedef struct packed {
        tmds_mode_e          mode;
        logic [CTRL_W-1:0]   ctrl;
        logic [TERC4_W-1:0]  terc4;
        logic [QM_W-1:0]     q_m;
        logic [POP_W-1:0]    n1q;
        logic [POP_W-1:0]    n0q;
    } stage1_t;

    function automatic logic [SYM_W-1:0] ctrl_symbol(input logic [CTRL_W-1:0] c);
        case (c)
            2'b00:   return CTRL_00;
            2'b01:   return CTRL_01;
            2'b10:   return CTRL_10;
            default: return CTRL_11;
        endcase
    endfunction

    function automatic logic [SYM_W-1:0] terc4_symbol(input logic [TERC4_W-1:0] t);
        case (t)
            4'h0:    return TERC4_0;
            4'h1:    return TERC4_1;
            4'h2:    return TERC4_2;
            4'h3:    return TERC4_3;
            4'h4:    return TERC4_4;
            4'h5:    return TERC4_5;
            4'h6:    return TERC4_6;
            4'h7:    return TERC4_7;
            4'h8:    return TERC4_8;
            4'h9:    return TERC4_9;
            4'hA:    return TERC4_A;
            4'hB:    return TERC4_B;
            4'hC:    return TERC4_C;
            4'hD:    return TERC4_D;
            4'hE:    return TERC4_E;
            default: return TERC4_F;
        endcase
    endfunction

    // Video guard band differs only on the middle lane.
    function automatic logic [SYM_W-1:0] guard_symbol(input int unsigned channel);
        return (channel == 1) ? GUARD_C1 : GUARD_C0C2;
    endfunction

endpackage

// File: rtl/tmds_qm_encoder.sv
// Transition-minimising stage of the TMDS video encoder (combinational).
// Ports: data  - pixel byte
//        q_m   - 9-bit minimised word, q_m[8]=1 for XOR chain, 0 for XNOR
//        n1q   - number of ones in q_m[7:0]
//        n0q   - number of zeros in q_m[7:0]
module tmds_qm_encoder
    import tmds_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [QM_W-1:0]   q_m,
    output logic [POP_W-1:0]  n1q,
    output logic [POP_W-1:0]  n0q
);

    logic [POP_W-1:0] n1d;
    logic             use_xnor;

    // XNOR chain is chosen when it yields fewer transitions for this byte.
    always_comb begin
        n1d = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            n1d = n1d + POP_W'(data[i]);
        end
        use_xnor = (n1d > POP_W'(4)) || ((n1d == POP_W'(4)) && !data[0]);

        q_m    = '0;
        q_m[0] = data[0];
        for (int i = 1; i < int'(DATA_W); i++) begin
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ data[i]) : (q_m[i-1] ^ data[i]);
        end
        q_m[DATA_W] = ~use_xnor;

        n1q = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            n1q = n1q + POP_W'(q_m[i]);
        end
        n0q = POP_W'(DATA_W) - n1q;
    end

endmodule

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane encoder: control, video (DC-balanced 8b/10b), TERC4 and
// guard-band symbols with a fixed two-cycle latency.
// Ports: hdmi_clk  - pixel clock
//        reset_n   - asynchronous active-low reset
//        mode      - 00 control, 01 video, 10 TERC4, 11 guard band
//        data      - pixel byte (video)
//        ctrl      - control bits (control)
//        terc4     - data-island nibble (TERC4)
//        out       - registered 10-bit symbol, bit 0 sent first
//        disparity - registered signed running disparity after out
// INVERT=1 sends symbols as-is; INVERT=0 sends their bitwise complement.
module tmds_channel_encoder
    import tmds_pkg::*;
#(
    parameter int unsigned CHANNEL = 0,
    parameter bit          INVERT  = 1'b0
) (
    input  logic                hdmi_clk,
    input  logic                reset_n,
    input  logic [MODE_W-1:0]   mode,
    input  logic [DATA_W-1:0]   data,
    input  logic [CTRL_W-1:0]   ctrl,
    input  logic [TERC4_W-1:0]  terc4,
    output logic [SYM_W-1:0]    out,
    output logic [CNT_W-1:0]    disparity
);

    localparam logic [SYM_W-1:0] GUARD_SYM = guard_symbol(CHANNEL);
    localparam logic [SYM_W-1:0] OUT_RST   = INVERT ? CTRL_00 : ~CTRL_00;

    logic [QM_W-1:0]      qm_c;
    logic [POP_W-1:0]     n1q_c;
    logic [POP_W-1:0]     n0q_c;
    stage1_t              st1_q;

    logic [SYM_W-1:0]     sym_c;
    logic [CNT_EXT_W-1:0] cnt_next_c;
    logic [CNT_EXT_W-1:0] cnt_ext_c;
    logic [CNT_EXT_W-1:0] diff_c;
    logic [CNT_EXT_W-1:0] two_q8_c;
    logic [CNT_EXT_W-1:0] two_nq8_c;
    logic [DATA_W-1:0]    qlo_c;
    logic                 q8_c;
    logic                 cnt_pos_c;
    logic                 cnt_neg_c;
    logic                 diff_pos_c;
    logic                 diff_neg_c;

    tmds_qm_encoder u_qm (
        .data (data),
        .q_m  (qm_c),
        .n1q  (n1q_c),
        .n0q  (n0q_c)
    );

    // Stage 1: sample controls together with the minimised video word.
    always_ff @(posedge hdmi_clk or negedge reset_n) begin
        if (!reset_n) begin
            st1_q <= '0;
        end else begin
            st1_q.mode  <= tmds_mode_e'(mode);
            st1_q.ctrl  <= ctrl;
            st1_q.terc4 <= terc4;
            st1_q.q_m   <= qm_c;
            st1_q.n1q   <= n1q_c;
            st1_q.n0q   <= n0q_c;
        end
    end

    // Stage 2 symbol select and running-disparity update (widened to avoid overflow).
    always_comb begin
        sym_c      = ctrl_symbol(st1_q.ctrl);
        cnt_next_c = '0;

        q8_c       = st1_q.q_m[DATA_W];
        qlo_c      = st1_q.q_m[DATA_W-1:0];
        cnt_ext_c  = {{(CNT_EXT_W-CNT_W){disparity[CNT_W-1]}}, disparity};
        diff_c     = CNT_EXT_W'(st1_q.n1q) - CNT_EXT_W'(st1_q.n0q);
        two_q8_c   = CNT_EXT_W'({q8_c, 1'b0});
        two_nq8_c  = CNT_EXT_W'({~q8_c, 1'b0});
        cnt_neg_c  = disparity[CNT_W-1];
        cnt_pos_c  = !cnt_neg_c && (disparity != '0);
        diff_neg_c = diff_c[CNT_EXT_W-1];
        diff_pos_c = !diff_neg_c && (diff_c != '0);

        case (st1_q.mode)
            MODE_VIDEO: begin
                if ((disparity == '0) || (diff_c == '0)) begin
                    sym_c      = {~q8_c, q8_c, (q8_c ? qlo_c : ~qlo_c)};
                    cnt_next_c = q8_c ? (cnt_ext_c + diff_c) : (cnt_ext_c - diff_c);
                end else if ((cnt_pos_c && diff_pos_c) || (cnt_neg_c && diff_neg_c)) begin
                    sym_c      = {1'b1, q8_c, ~qlo_c};
                    cnt_next_c = cnt_ext_c + two_q8_c - diff_c;
                end else begin
                    sym_c      = {1'b0, q8_c, qlo_c};
                    cnt_next_c = cnt_ext_c - two_nq8_c + diff_c;
                end
            end
            MODE_TERC4: sym_c = terc4_symbol(st1_q.terc4);
            MODE_GUARD: sym_c = GUARD_SYM;
            default:    ;
        endcase
    end

    // Stage 2 output register; non-video symbols leave cnt at zero.
    always_ff @(posedge hdmi_clk or negedge reset_n) begin
        if (!reset_n) begin
            out       <= OUT_RST;
            disparity <= '0;
        end else begin
            out       <= INVERT ? sym_c : ~sym_c;
            disparity <= CNT_W'(cnt_next_c);
        end
    end

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: two lanes (CHANNEL 0 non-inverted,
// CHANNEL 1 inverted) share one stimulus stream; a reference model predicts
// each symbol and a monitor checks symbol, disparity, decode and stream balance.
module tb_tmds_channel_encoder;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] mode    = 2'b00;
    logic [7:0] data    = 8'h00;
    logic [1:0] ctrl    = 2'b00;
    logic [3:0] terc4   = 4'h0;
    logic [9:0] out_a;
    logic [9:0] out_b;
    logic [4:0] disp_a;
    logic [4:0] disp_b;

    always #5 clk = ~clk;

    tmds_channel_encoder #(.CHANNEL(0), .INVERT(1'b1)) dut_a (
        .hdmi_clk  (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .data      (data),
        .ctrl      (ctrl),
        .terc4     (terc4),
        .out       (out_a),
        .disparity (disp_a)
    );

    tmds_channel_encoder #(.CHANNEL(1), .INVERT(1'b0)) dut_b (
        .hdmi_clk  (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .data      (data),
        .ctrl      (ctrl),
        .terc4     (terc4),
        .out       (out_b),
        .disparity (disp_b)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] data;
        logic [9:0] sym_a;
        logic [9:0] sym_b;
        int         cnt;
        int         issue;
    } exp_t;

    exp_t sb_q[$];
    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;
    int   model_cnt  = 0;
    int   stream_bal = 0;

    logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011,
                                 10'b0101010100, 10'b1010101011};
    logic [9:0] terc_tab [16] = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                                  10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                                  10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                                  10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    logic [9:0] guard_c02 = 10'b1011001100;
    logic [9:0] guard_c1  = 10'b0100110011;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: symbol for both lanes and the disparity after it.
    function automatic void model_step(input logic [1:0] m, input logic [7:0] d,
                                       input logic [1:0] c, input logic [3:0] t,
                                       inout int cnt,
                                       output logic [9:0] sa, output logic [9:0] sb);
        int   ones;
        int   bal;
        bit   use_xnor;
        bit   par;
        bit   q8;
        logic [7:0] q;
        sa = '0;
        sb = '0;
        case (m)
            2'b00: begin sa = ctrl_tab[c]; sb = sa; cnt = 0; end
            2'b10: begin sa = terc_tab[t]; sb = sa; cnt = 0; end
            2'b11: begin sa = guard_c02; sb = guard_c1; cnt = 0; end
            default: begin
                ones     = $countones(d);
                use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
                par      = 1'b0;
                // XOR chain = prefix parity; XNOR chain flips every odd bit.
                for (int i = 0; i < 8; i++) begin
                    par  = par ^ d[i];
                    q[i] = use_xnor ? (par ^ (i % 2 == 1)) : par;
                end
                q8  = !use_xnor;
                bal = 2 * $countones(q) - 8;
                if (cnt == 0 || bal == 0) begin
                    sa  = {~q8, q8, (q8 ? q : ~q)};
                    cnt = cnt + (q8 ? bal : -bal);
                end else if ((cnt > 0) == (bal > 0)) begin
                    sa  = {1'b1, q8, ~q};
                    cnt = cnt + 2 * int'(q8) - bal;
                end else begin
                    sa  = {1'b0, q8, q};
                    cnt = cnt - 2 * int'(!q8) + bal;
                end
                sb = sa;
            end
        endcase
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    task automatic drive_push(input logic [1:0] m, input logic [7:0] d,
                              input logic [1:0] c, input logic [3:0] t);
        exp_t e;
        mode  = m;
        data  = d;
        ctrl  = c;
        terc4 = t;
        model_step(m, d, c, t, model_cnt, e.sym_a, e.sym_b);
        e.mode  = m;
        e.data  = d;
        e.cnt   = model_cnt;
        e.issue = cyc;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] m, input logic [7:0] d,
                         input logic [1:0] c, input logic [3:0] t);
        @(negedge clk);
        drive_push(m, d, c, t);
    endtask

    // Monitor: each symbol is due two edges after its inputs were driven.
    initial begin
        exp_t       e;
        logic [9:0] inv_b;
        int         da;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!reset_n) continue;
            while (sb_q.size() > 0 && sb_q[0].issue + 2 < cyc) begin
                compared++;
                mismatched++;
                $display("FAIL stale: symbol issued at cycle %0d never checked (now %0d)",
                         sb_q[0].issue, cyc);
                void'(sb_q.pop_front());
            end
            if (sb_q.size() > 0 && sb_q[0].issue + 2 == cyc) begin
                e     = sb_q.pop_front();
                inv_b = ~e.sym_b;
                da    = int'($signed(disp_a));
                check("out_lane0", 32'(out_a), 32'(e.sym_a));
                check("out_lane1_inv", 32'(out_b), 32'(inv_b));
                check("disparity_lane0", da, e.cnt);
                check("disparity_lane1", int'($signed(disp_b)), e.cnt);
                if (e.mode == 2'b01) begin
                    stream_bal = stream_bal + 2 * $countones(out_a) - 10;
                    check("decode", 32'(decode(out_a)), 32'(e.data));
                    check("stream_balance", da, stream_bal);
                    check("cnt_range", 32'(da >= -8 && da <= 8), 32'd1);
                end else begin
                    stream_bal = 0;
                end
            end
        end
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_out_lane0", 32'(out_a), 32'(10'b1101010100));
        check("rst_out_lane1", 32'(out_b), 32'(10'b0010101011));
        check("rst_disparity", 32'(disp_a), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) issue(2'b00, 8'h00, 2'b00, 4'h0);

        // Video 0x00 x3, then 0xFF, then control 11.
        repeat (3) issue(2'b01, 8'h00, 2'b00, 4'h0);
        issue(2'b00, 8'h00, 2'b00, 4'h0);
        issue(2'b01, 8'hFF, 2'b00, 4'h0);
        issue(2'b00, 8'h00, 2'b11, 4'h0);

        // Control words, TERC4 sweep and guard bands back to back.
        for (int c = 0; c < 4; c++) issue(2'b00, 8'h00, 2'(c), 4'h0);
        for (int t = 0; t < 16; t++) issue(2'b10, 8'h00, 2'b00, 4'(t));
        issue(2'b11, 8'h00, 2'b00, 4'h0);
        issue(2'b11, 8'h00, 2'b00, 4'h0);
        issue(2'b01, 8'h5A, 2'b00, 4'h0);
        issue(2'b01, 8'h10, 2'b00, 4'h0);

        // Random video with occasional non-video symbols.
        for (int n = 0; n < 20000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                logic [1:0] rm;
                rm = 2'($urandom_range(0, 3));
                if (rm == 2'b01) rm = 2'b11;
                issue(rm, 8'h00, 2'($urandom), 4'($urandom));
            end else begin
                issue(2'b01, 8'($urandom), 2'b00, 4'h0);
            end
        end

        // Reset in the middle of a video burst.
        repeat (5) issue(2'b01, 8'($urandom), 2'b00, 4'h0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_out_lane0", 32'(out_a), 32'(10'b1101010100));
        check("async_rst_out_lane1", 32'(out_b), 32'(10'b0010101011));
        check("async_rst_disparity", 32'(disp_a), 32'd0);
        sb_q.delete();
        model_cnt  = 0;
        stream_bal = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        drive_push(2'b01, 8'h00, 2'b00, 4'h0);
        @(posedge clk);
        #1;
        check("post_rst_flush_out", 32'(out_a), 32'(10'b1101010100));
        check("post_rst_flush_disp", 32'(disp_a), 32'd0);
        for (int n = 0; n < 50; n++) issue(2'b01, 8'($urandom), 2'b00, 4'h0);

        repeat (4) @(negedge clk);
        if (sb_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d symbols left unchecked", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tmds_channel_encoder.md
TMDS_CHANNEL_ENCODER -- requirements
Module: tmds_channel_encoder

Interface
REQ-001 SHALL have parameter CHANNEL, default 0, meaning the TMDS lane index (0..2); it selects the video guard-band word.
REQ-002 SHALL have parameter INVERT, default 1'b0, meaning the output is bitwise-inverted when 0, matching the lane polarity convention of the receive path.
REQ-003 SHALL have port hdmi_clk, input, 1 bit: the pixel clock; the only clock.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port mode, input, 2 bits: 00 control, 01 video, 10 TERC4 data island, 11 guard band.
REQ-006 SHALL have port data, input, 8 bits: the video pixel byte, used when mode is 01.
REQ-007 SHALL have port ctrl, input, 2 bits: {ctrl[1], ctrl[0]} control bits (hsync/vsync on lane 0), used when mode is 00.
REQ-008 SHALL have port terc4, input, 4 bits: the data-island nibble, used when mode is 10.
REQ-009 SHALL have port out, output, 10 bits: the encoded TMDS symbol, registered, bit 0 transmitted first.
REQ-010 SHALL have port disparity, output, 5 bits: the signed running disparity after the symbol now on out, registered.

Function
REQ-011 SHALL register mode, data, ctrl and terc4 in stage 1, so out reflects the inputs sampled 2 hdmi_clk edges earlier; latency is fixed at 2.
REQ-012 Stage 1 SHALL compute n1d = popcount(data) and use XNOR when n1d>4 or (n1d==4 and data[0]==0), else XOR.
REQ-013 Stage 1 SHALL form q_m[0]=data[0], q_m[i]=q_m[i-1] XOR/XNOR data[i], with q_m[8]=1 for XOR and 0 for XNOR.
REQ-014 Stage 2 video, case cnt==0 or n1q==n0q (counts over q_m[7:0]): out={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}; cnt += q_m[8]?(n1q-n0q):(n0q-n1q).
REQ-015 Stage 2 video, case (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q): out={1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + (n0q-n1q).
REQ-016 Stage 2 video, all other cases: out={0, q_m[8], q_m[7:0]}; cnt += -2*(~q_m[8]) + (n1q-n0q).
REQ-017 cnt SHALL be 5-bit two's complement; the arithmetic SHALL be sized so no intermediate overflows, and the result always lies within -8..+8.
REQ-018 Control mode SHALL map ctrl 00/01/10/11 to 1101010100/0010101011/0101010100/1010101011.
REQ-019 TERC4 mode SHALL map nibble 0..F to the standard HDMI TERC4 table: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011.
REQ-020 Guard-band mode SHALL emit 1011001100 for CHANNEL 0 and 2, and 0100110011 for CHANNEL 1.
REQ-021 Any non-video symbol leaving stage 2 SHALL clear cnt to 0 on the same edge.
REQ-022 A mode change SHALL travel down the pipeline with its data; a video symbol following a non-video symbol SHALL start from cnt=0, with no bubble cycles.
REQ-023 When INVERT=0, out SHALL be the bitwise complement of the symbols above.
REQ-024 The disparity output SHALL equal cnt after the symbol currently on out.

Reset
REQ-025 While reset_n is low, all pipeline registers, cnt and disparity SHALL be 0, and stage 2 SHALL hold control mode with ctrl=00.
REQ-026 out SHALL reset to 1101010100 (INVERT=1) or 0010101011 (INVERT=0); deassertion SHALL take effect on the next hdmi_clk edge; reset mid-stream SHALL drop in-flight symbols.

Structure
REQ-027 The CTRL_xx, TERC4_x and guard-band constants and the mode encodings SHALL live in a shared tmds package/include, also used by the receive path.
REQ-028 The XOR/XNOR minimisation stage SHALL be the sub-module tmds_qm_encoder (combinational q_m plus n1q/n0q); the DC-balance logic, cnt and the output mux SHALL stay in the top level.

Verification
REQ-029 Reset with INVERT=1, CHANNEL=0: out==1101010100 and disparity==0, during reset and 2 cycles after release with mode=00, ctrl=00.
REQ-030 Video 0x00 ×3 from cnt=0, INVERT=1: out = 0100000000 (cnt -8), then 1111111111 (cnt +2), then 0100000000 (cnt -6).
REQ-031 Video 0xFF from cnt=0: out==1000000000, cnt==-8; then mode 00 with ctrl=11: out==1010101011, cnt==0.
REQ-032 Sweep terc4 0..F in mode 10, and mode 11 with CHANNEL 0/1: every out matches REQ-019/REQ-020 exactly, 2 cycles after input.
REQ-033 Random 10^5 video bytes through the encoder and then the receive decoder: decoded byte == input, |cnt|<=8 at all times, cumulative (ones-zeros) of the emitted stream == disparity.
REQ-034 Assert reset_n low mid-video-burst, then release: out returns to the REQ-026 value asynchronously, and the first post-reset video symbol is encoded from cnt=0.
